// File: rtl/bbox_msg_reader.sv
// rtl/bbox_msg_reader.sv - Avalon-MM master draining RBB bounding-box messages
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 run enable; sampled only in IDLE so a message is never split
//   m_chipselect           high with every m_read / m_write
//   m_address[2:0]         0 = status, 1 = message FIFO, 2 = device ID
//   m_read, m_write        single-cycle strobes, always separated by an idle cycle
//   m_writedata[31:0]      write data (32'h10 flushes the slave FIFO)
//   m_readdata[31:0]       slave read data, sampled READ_LATENCY cycles after m_read
//   bb_valid, bb_ready     decoded box handshake
//   bb_left/top/right/bottom[10:0]  box coordinates
//   bb_empty               box holds no red pixels (left > right)
//   dev_ok, dev_err        ID check passed / sticky ID mismatch
//   resync_count[7:0]      saturating count of discarded non-header words
module bbox_msg_reader #(
    parameter int          POLL_INTERVAL = 64,
    parameter int          READ_LATENCY  = 1,
    parameter logic [31:0] DEV_ID        = 32'h1234EEE2,
    parameter logic [31:0] MSG_ID        = 32'h00524242
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        m_chipselect,
    output logic [2:0]  m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        bb_valid,
    input  logic        bb_ready,
    output logic [10:0] bb_left,
    output logic [10:0] bb_top,
    output logic [10:0] bb_right,
    output logic [10:0] bb_bottom,
    output logic        bb_empty,
    output logic        dev_ok,
    output logic        dev_err,
    output logic [7:0]  resync_count
);

    typedef enum logic [3:0] {
        S_RST_ID,
        S_HALT,
        S_FLUSH,
        S_IDLE,
        S_POLL,
        S_BACKOFF,
        S_RD_HDR,
        S_RD_TL,
        S_RD_BR,
        S_PRESENT
    } state_t;

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_MSG    = 3'd1;
    localparam logic [2:0]  ADDR_ID     = 3'd2;
    localparam logic [15:0] RD_LAT      = 16'(READ_LATENCY);
    // BACKOFF plus the single IDLE cycle that follows it together make up
    // POLL_INTERVAL idle bus cycles between a poll's data sample and the next poll.
    localparam logic [15:0] BACKOFF_LAST = (POLL_INTERVAL > 1) ? 16'(POLL_INTERVAL - 2) : 16'd0;
    localparam bit          USE_BACKOFF  = (POLL_INTERVAL > 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic        sample;

    assign m_chipselect = m_read | m_write;
    assign bb_valid     = (state == S_PRESENT);

    always_comb begin
        state_next  = state;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_address   = ADDR_STATUS;
        m_writedata = 32'h0;
        sample      = 1'b0;
        case (state)
            S_RST_ID: begin
                // One quiet cycle before the ID read guarantees strobes stay low
                // while reset is held and leaves a gap after a mid-transfer reset.
                m_address = ADDR_ID;
                m_read    = (cnt == 16'd1);
                sample    = (cnt == RD_LAT + 16'd1);
                if (sample) begin
                    state_next = (m_readdata == DEV_ID) ? S_FLUSH : S_HALT;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            S_FLUSH: begin
                m_write     = 1'b1;
                m_writedata = 32'h10;
                state_next  = S_IDLE;
            end
            S_IDLE: begin
                if (enable) begin
                    state_next = S_POLL;
                end
            end
            S_POLL: begin
                m_read = (cnt == 16'd0);
                sample = (cnt == RD_LAT);
                if (sample) begin
                    if (m_readdata[15:8] >= 8'd3) begin
                        state_next = S_RD_HDR;
                    end else if (USE_BACKOFF) begin
                        state_next = S_BACKOFF;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_BACKOFF: begin
                if (cnt >= BACKOFF_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_RD_HDR: begin
                m_address = ADDR_MSG;
                m_read    = (cnt == 16'd0);
                sample    = (cnt == RD_LAT);
                if (sample) begin
                    state_next = (m_readdata == MSG_ID) ? S_RD_TL : S_IDLE;
                end
            end
            S_RD_TL: begin
                m_address = ADDR_MSG;
                m_read    = (cnt == 16'd0);
                sample    = (cnt == RD_LAT);
                if (sample) begin
                    state_next = S_RD_BR;
                end
            end
            S_RD_BR: begin
                m_address = ADDR_MSG;
                m_read    = (cnt == 16'd0);
                sample    = (cnt == RD_LAT);
                if (sample) begin
                    state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bb_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_RST_ID;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_RST_ID;
            cnt          <= 16'd0;
            dev_ok       <= 1'b0;
            dev_err      <= 1'b0;
            resync_count <= 8'd0;
            bb_left      <= 11'd0;
            bb_top       <= 11'd0;
            bb_right     <= 11'd0;
            bb_bottom    <= 11'd0;
            bb_empty     <= 1'b0;
        end else begin
            state <= state_next;
            // Cycle counter within a state; saturates so long waits never re-trigger a strobe.
            if (state_next != state) begin
                cnt <= 16'd0;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
            if (sample) begin
                case (state)
                    S_RST_ID: begin
                        if (m_readdata == DEV_ID) begin
                            dev_ok <= 1'b1;
                        end else begin
                            dev_ok  <= 1'b0;
                            dev_err <= 1'b1;
                        end
                    end
                    S_RD_HDR: begin
                        if (m_readdata != MSG_ID && resync_count != 8'hFF) begin
                            resync_count <= resync_count + 8'd1;
                        end
                    end
                    S_RD_TL: begin
                        bb_left <= m_readdata[26:16];
                        bb_top  <= m_readdata[10:0];
                    end
                    S_RD_BR: begin
                        bb_right  <= m_readdata[26:16];
                        bb_bottom <= m_readdata[10:0];
                        bb_empty  <= (bb_left > m_readdata[26:16]);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bbox_msg_reader.sv
// tb/tb_bbox_msg_reader.sv - randomized self-checking bench for bbox_msg_reader
module tb_bbox_msg_reader;

    localparam int          P      = 8;
    localparam logic [31:0] MSG    = 32'h00524242;
    localparam logic [31:0] DEVID  = 32'h1234EEE2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        m_chipselect;
    logic [2:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'h0;
    logic        bb_valid;
    logic        bb_ready = 1'b0;
    logic [10:0] bb_left, bb_top, bb_right, bb_bottom;
    logic        bb_empty;
    logic        dev_ok, dev_err;
    logic [7:0]  resync_count;

    always #5 clk = ~clk;

    bbox_msg_reader #(.POLL_INTERVAL(P)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_chipselect(m_chipselect), .m_address(m_address), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .bb_valid(bb_valid), .bb_ready(bb_ready),
        .bb_left(bb_left), .bb_top(bb_top), .bb_right(bb_right), .bb_bottom(bb_bottom),
        .bb_empty(bb_empty), .dev_ok(dev_ok), .dev_err(dev_err), .resync_count(resync_count)
    );

    logic [44:0] cur_box;
    assign cur_box = {bb_empty, bb_left, bb_top, bb_right, bb_bottom};

    // Slave model: message FIFO as array with separate push/pop pointers.
    logic [31:0] mem [0:4095];
    int          wp = 0;
    int          rp = 0;
    logic [31:0] id_val = DEVID;

    function automatic logic [7:0] usedw();
        int n;
        n = wp - rp;
        return (n > 255) ? 8'hFF : 8'(n);
    endfunction

    always @(posedge clk) begin
        if (m_read) begin
            case (m_address)
                3'd0: m_readdata <= {16'h0, usedw(), 8'h0};
                3'd1: begin
                    if (rp < wp) begin
                        m_readdata <= mem[rp];
                        rp <= rp + 1;
                    end else begin
                        m_readdata <= 32'h0;
                    end
                end
                3'd2: m_readdata <= id_val;
                default: m_readdata <= 32'h0;
            endcase
        end
        if (m_write && m_address == 3'd0 && m_writedata == 32'h10) rp <= wp;
    end

    // Bus monitor and consumer.
    int          cyc = 0, viol = 0, strobes = 0, rd0 = 0, rd1 = 0, rd2 = 0, wr_cnt = 0, vcnt = 0;
    int          last_poll = 0, prev_poll = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [2:0]  last_waddr = 3'd0;
    logic        prev_strobe = 1'b0, prev_hold = 1'b0;
    logic [44:0] prev_box = '0;
    logic [44:0] got_q[$];
    int          rdy_mode = 1;

    always @(negedge clk) begin
        cyc++;
        if (m_chipselect !== (m_read | m_write)) viol++;
        if ((m_read | m_write) && prev_strobe) viol++;
        if (bb_valid && (m_read | m_write)) viol++;
        if (prev_hold && (bb_valid !== 1'b1 || cur_box !== prev_box)) viol++;
        prev_strobe = m_read | m_write;
        if (bb_valid) vcnt++;
        if (m_read) begin
            strobes++;
            case (m_address)
                3'd0: begin prev_poll = last_poll; last_poll = cyc; rd0++; end
                3'd1: rd1++;
                3'd2: rd2++;
                default: viol++;
            endcase
        end
        if (m_write) begin
            strobes++;
            wr_cnt++;
            last_wdata = m_writedata;
            last_waddr = m_address;
        end
        case (rdy_mode)
            0: bb_ready = 1'b0;
            1: bb_ready = 1'b1;
            default: bb_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (bb_valid && bb_ready) got_q.push_back(cur_box);
        prev_hold = reset_n && bb_valid && !bb_ready;
        prev_box  = cur_box;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wp] = w;
        wp = wp + 1;
    endtask

    function automatic logic [44:0] model_box(input logic [31:0] a, input logic [31:0] b);
        logic [10:0] l, t, r, bt;
        l  = a[26:16];
        t  = a[10:0];
        r  = b[26:16];
        bt = b[10:0];
        return {(l > r), l, t, r, bt};
    endfunction

    task automatic wait_dev_ok(input string tag);
        int c;
        c = 0;
        while (!dev_ok && c < 50) begin tick(1); c++; end
        check_eq(tag, dev_ok, 1);
    endtask

    task automatic wait_boxes(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin tick(1); c++; end
        check_eq(tag, (got_q.size() >= n), 1);
    endtask

    logic [44:0] exp_q[$];
    logic [31:0] words[$];
    int gi = 0, base_a = 0, base_b = 0, base_c = 0, leftover = 0, junk = 0, exp_resync = 0;
    int hit = 0;
    logic [44:0] box1;

    initial begin
        // Reset state and ID/flush sequence.
        rdy_mode = 1;
        enable   = 1'b0;
        reset_n  = 1'b0;
        tick(3);
        check_eq("rst_ctl", {bb_valid, bb_empty, dev_ok, dev_err, m_read, m_write, m_chipselect, resync_count}, 0);
        check_eq("rst_box", cur_box, 0);
        reset_n = 1'b1;
        wait_dev_ok("id_ok");
        tick(5);
        check_eq("id_no_err", dev_err, 0);
        check_eq("flush_count", wr_cnt, 1);
        check_eq("flush_word", {last_waddr, last_wdata}, {3'd0, 32'h10});
        check_eq("id_reads", rd2, 1);
        check_eq("no_poll_disabled", rd0, 0);

        // Directed box with consumer stalled 50 cycles.
        rdy_mode = 0;
        push(MSG); push(32'h0064_0032); push(32'h00C8_0096);
        base_a = rd0 + rd1;
        enable = 1'b1;
        hit = 0;
        for (int k = 0; k < 100 && hit == 0; k++) begin tick(1); if (bb_valid) hit = 1; end
        check_eq("box1_valid", hit, 1);
        box1 = {1'b0, 11'd100, 11'd50, 11'd200, 11'd150};
        check_eq("box1_reads", (rd0 + rd1) - base_a, 4);
        check_eq("box1", cur_box, box1);
        base_b = strobes;
        tick(50);
        check_eq("hold_valid", bb_valid, 1);
        check_eq("hold_box", cur_box, box1);
        check_eq("hold_no_strobe", strobes - base_b, 0);
        rdy_mode = 1;
        wait_boxes(gi + 1, 20, "box1_xfer");
        if (got_q.size() > gi) begin check_eq("box1_got", got_q[gi], box1); gi++; end
        tick(2);
        check_eq("valid_drop", bb_valid, 0);

        // Poll spacing with an empty FIFO.
        base_a = rd0;
        base_b = rd1;
        for (int k = 0; k < 300 && rd0 < base_a + 3; k++) tick(1);
        check_eq("poll_interval", last_poll - prev_poll, P + 2);
        check_eq("no_msg_reads", rd1 - base_b, 0);

        // Immediate-ready empty box: bb_valid lasts exactly one cycle.
        base_c = vcnt;
        push(MSG); push(32'h027F_0000); push(32'h0000_0000);
        wait_boxes(gi + 1, 200, "empty_xfer");
        if (got_q.size() > gi) begin check_eq("empty_box", got_q[gi], {1'b1, 11'd639, 11'd0, 11'd0, 11'd0}); gi++; end
        tick(2);
        check_eq("valid_one_cycle", vcnt - base_c, 1);

        // Single bad header, then a good message.
        push(32'h0000_0123);
        push(MSG); push(32'h0001_0002); push(32'h0003_0004);
        wait_boxes(gi + 1, 300, "resync_xfer");
        if (got_q.size() > gi) begin check_eq("resync_box", got_q[gi], model_box(32'h0001_0002, 32'h0003_0004)); gi++; end
        check_eq("resync_one", resync_count, 1);

        // Randomized stream of messages and junk words, random ready and enable.
        tick(20);
        words.delete();
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                words.push_back(MSG);
                words.push_back($urandom);
                words.push_back($urandom);
            end else begin
                words.push_back(($urandom == MSG) ? 32'h1 : $urandom);
            end
        end
        for (int k = 0; k < words.size(); k++) if (words[k] == MSG && k > 0) ;
        junk = 0;
        begin
            int i;
            i = 0;
            while (words.size() - i >= 3) begin
                if (words[i] == MSG) begin
                    exp_q.push_back(model_box(words[i + 1], words[i + 2]));
                    i += 3;
                end else begin
                    junk++;
                    i++;
                end
            end
            leftover = words.size() - i;
        end
        exp_resync = (1 + junk > 255) ? 255 : 1 + junk;
        for (int k = 0; k < words.size(); k++) push(words[k]);
        rdy_mode = 2;
        base_a = gi;
        for (int c = 0; c < 20000 && got_q.size() < base_a + exp_q.size(); c++) begin
            enable = ($urandom_range(0, 4) != 0);
            tick(1);
        end
        enable = 1'b1;
        check_eq("rand_count", got_q.size(), base_a + exp_q.size());
        for (int c = 0; c < 2000 && (wp - rp) != leftover; c++) tick(1);
        tick(10);
        check_eq("rand_leftover", wp - rp, leftover);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (got_q.size() > gi) begin check_eq($sformatf("rand_box%0d", k), got_q[gi], exp_q[k]); gi++; end
        end
        check_eq("rand_resync", resync_count, exp_resync);

        // Resync counter saturation.
        rdy_mode = 1;
        reset_n = 1'b0;
        tick(2);
        check_eq("rst_resync", resync_count, 0);
        reset_n = 1'b1;
        wait_dev_ok("id_ok2");
        tick(3);
        base_a = 0;
        for (int c = 0; c < 20000 && base_a < 300; c++) begin
            if (wp - rp < 8) begin push(32'h0000_0123); base_a++; end
            tick(1);
        end
        for (int c = 0; c < 500 && (wp - rp) >= 3; c++) tick(1);
        tick(10);
        check_eq("resync_sat", resync_count, 255);

        // Reset while the top-left word is being read.
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        wait_dev_ok("id_ok3");
        tick(3);
        base_b = rd1;
        push(MSG); push(32'h0005_0006); push(32'h0007_0008);
        hit = 0;
        for (int k = 0; k < 200 && hit == 0; k++) begin
            tick(1);
            if (m_read && m_address == 3'd1 && rd1 == base_b + 1) hit = 1;
        end
        check_eq("tl_reached", hit, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_strobe_drop", {m_read, m_write, m_chipselect}, 0);
        check_eq("rst_mid_ctl", {dev_ok, bb_valid, resync_count}, 0);
        check_eq("rst_mid_box", cur_box, 0);
        tick(2);
        base_a = rd2;
        base_b = wr_cnt;
        reset_n = 1'b1;
        wait_dev_ok("id_ok4");
        tick(3);
        check_eq("reid_reads", rd2 - base_a, 1);
        check_eq("reflush", wr_cnt - base_b, 1);

        // Wrong device ID: halt with no further bus activity.
        id_val = 32'hDEADBEEF;
        reset_n = 1'b0;
        tick(2);
        base_a = strobes;
        reset_n = 1'b1;
        tick(1000);
        check_eq("bad_id_err", dev_err, 1);
        check_eq("bad_id_ok", dev_ok, 0);
        check_eq("bad_id_strobes", strobes - base_a, 1);

        check_eq("bus_rules", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
